// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32 control path: FSM states, opcodes,
// instruction classes and datapath selector codes.
package riscv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IF  = 3'd0,
    ST_ID  = 3'd1,
    ST_EX  = 3'd2,
    ST_MEM = 3'd3,
    ST_WB  = 3'd4
  } state_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BLT = 3'b100;

  typedef enum logic [3:0] {
    CLS_RTYPE,
    CLS_ITYPE,
    CLS_LOAD,
    CLS_STORE,
    CLS_BEQ,
    CLS_BLT,
    CLS_JAL,
    CLS_JALR,
    CLS_AUIPC
  } cls_t;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JALR   = 2'b10;

endpackage

// File: rtl/ctrl_class_decode.sv
// Combinational opcode/funct3 classifier; legal=0 flags anything the
// controller does not execute.
module ctrl_class_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  output cls_t       cls,
  output logic       legal
);

  always_comb begin
    cls   = CLS_RTYPE;
    legal = 1'b1;
    case (opcode)
      OP_RTYPE: cls = CLS_RTYPE;
      OP_ITYPE: cls = CLS_ITYPE;
      OP_LOAD:  cls = CLS_LOAD;
      OP_STORE: cls = CLS_STORE;
      OP_JAL:   cls = CLS_JAL;
      OP_JALR:  cls = CLS_JALR;
      OP_AUIPC: cls = CLS_AUIPC;
      OP_BRANCH: begin
        if (funct3 == F3_BEQ)      cls = CLS_BEQ;
        else if (funct3 == F3_BLT) cls = CLS_BLT;
        else                       legal = 1'b0;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 control FSM (IF/ID/EX/MEM/WB). Outputs depend on the state
// and the instruction class latched in ID, plus the few handshake inputs.
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       lt,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IorD,
  output logic [1:0] ALUsrcA,
  output logic [1:0] ALUsrcB,
  output logic [1:0] ALUop,
  output logic [1:0] MemtoReg,
  output logic [1:0] PCsrc,
  output logic [2:0] state,
  output logic       inst_done,
  output logic       illegal
);

  state_t state_q, state_d;
  cls_t   cls_q, cls_d;
  cls_t   dec_cls;
  logic   dec_legal;

  ctrl_class_decode u_decode (
    .opcode (opcode),
    .funct3 (funct3),
    .cls    (dec_cls),
    .legal  (dec_legal)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IF;
      cls_q   <= CLS_RTYPE;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
    end
  end

  assign state = state_q;

  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = ST_IF;
    cls_d     = cls_q;
    PCWrite   = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    IorD      = 1'b0;
    ALUsrcA   = SRCA_PC;
    ALUsrcB   = SRCB_RS2;
    ALUop     = ALUOP_ADD;
    MemtoReg  = M2R_ALUOUT;
    PCsrc     = PCSRC_ALU;
    inst_done = 1'b0;
    illegal   = 1'b0;

    case (state_q)
      ST_IF: begin
        MemRead = 1'b1;
        ALUsrcB = SRCB_FOUR;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        state_d = mem_ready ? ST_ID : ST_IF;
      end

      // Branch/jal/auipc target is precomputed into ALUOut here.
      ST_ID: begin
        ALUsrcA = SRCA_OLDPC;
        ALUsrcB = SRCB_IMM;
        if (dec_legal) begin
          cls_d   = dec_cls;
          state_d = ST_EX;
        end else begin
          illegal = 1'b1;
          state_d = ST_IF;
        end
      end

      ST_EX: begin
        case (cls_q)
          CLS_RTYPE: begin
            ALUsrcA = SRCA_RS1;
            ALUop   = ALUOP_FUNCT;
            state_d = ST_WB;
          end
          CLS_ITYPE, CLS_JALR, CLS_LOAD, CLS_STORE: begin
            ALUsrcA = SRCA_RS1;
            ALUsrcB = SRCB_IMM;
            state_d = (cls_q == CLS_LOAD || cls_q == CLS_STORE) ? ST_MEM : ST_WB;
          end
          CLS_BEQ, CLS_BLT: begin
            ALUsrcA   = SRCA_RS1;
            ALUop     = ALUOP_BRANCH;
            PCsrc     = PCSRC_ALUOUT;
            PCWrite   = (cls_q == CLS_BEQ) ? zero : lt;
            inst_done = 1'b1;
          end
          CLS_JAL: begin
            RegWrite  = 1'b1;
            MemtoReg  = M2R_PC;
            PCWrite   = 1'b1;
            PCsrc     = PCSRC_ALUOUT;
            inst_done = 1'b1;
          end
          CLS_AUIPC: begin
            RegWrite  = 1'b1;
            inst_done = 1'b1;
          end
          default: state_d = ST_IF;
        endcase
      end

      ST_MEM: begin
        IorD = 1'b1;
        if (cls_q == CLS_STORE) begin
          MemWrite  = 1'b1;
          inst_done = mem_ready;
        end else begin
          MemRead = 1'b1;
        end
        if (!mem_ready)                state_d = ST_MEM;
        else if (cls_q == CLS_STORE)   state_d = ST_IF;
        else                           state_d = ST_WB;
      end

      ST_WB: begin
        RegWrite  = 1'b1;
        inst_done = 1'b1;
        case (cls_q)
          CLS_LOAD: MemtoReg = M2R_MDR;
          // Keep the EX operands so rs1+imm is still on the ALU result.
          CLS_JALR: begin
            MemtoReg = M2R_PC;
            PCWrite  = 1'b1;
            PCsrc    = PCSRC_JALR;
            ALUsrcA  = SRCA_RS1;
            ALUsrcB  = SRCB_IMM;
          end
          default: MemtoReg = M2R_ALUOUT;
        endcase
      end

      default: state_d = ST_IF;
    endcase

    if (rst) begin
      PCWrite   = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      MemWrite  = 1'b0;
      inst_done = 1'b0;
      illegal   = 1'b0;
    end
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have these inputs:
- opcode, 7 bits: IR[6:0].
- funct3, 3 bits: IR[14:12].
- zero, 1 bit: ALU result == 0.
- lt, 1 bit: ALU signed less-than.
- mem_ready, 1 bit: memory access completes this cycle.
REQ-004 The block SHALL have these outputs:
- PCWrite, IRWrite, RegWrite, MemRead, MemWrite, IorD: 1 bit each.
- ALUsrcA[1:0]: 00 = PC, 01 = oldPC, 10 = rs1.
- ALUsrcB[1:0]: 00 = rs2, 01 = const 4, 10 = imm.
- ALUop[1:0]: 00 = add, 01 = branch compare, 10 = funct decode.
- MemtoReg[1:0]: 00 = ALUOut, 01 = MDR, 10 = PC.
- PCsrc[1:0]: 00 = ALU result, 01 = ALUOut, 10 = {ALU result[31:1], 0}.
REQ-005 The block SHALL have these status outputs, 1 bit each unless stated:
- state[2:0]: debug view of the FSM state.
- inst_done: 1-cycle pulse on an instruction's last cycle.
- illegal: 1-cycle pulse when an unsupported opcode is seen in ID.

Function
REQ-006 The FSM SHALL have states IF=0, ID=1, EX=2, MEM=3, WB=4; all outputs are Moore functions of the state and the latched class; every output not listed for a state is 0.
REQ-007 IF SHALL drive MemRead=1, IorD=0, ALUsrcA=00, ALUsrcB=01, ALUop=00, PCsrc=00.
- IRWrite and PCWrite SHALL equal mem_ready.
- IF SHALL hold until mem_ready=1, then go to ID.
REQ-008 ID SHALL drive ALUsrcA=01, ALUsrcB=10, ALUop=00 (branch/jal/auipc target into ALUOut).
- ID SHALL latch the class from opcode/funct3: RTYPE 0110011, ITYPE 0010011, LOAD 0000011, STORE 0100011, BEQ 1100011/000, BLT 1100011/100, JAL 1101111, JALR 1100111, AUIPC 0010111.
- Any other opcode, or any other 1100011 funct3, SHALL pulse illegal, make no writes, and go to IF.
REQ-009 EX SHALL act per class:
- RTYPE: ALUsrcA=10, ALUsrcB=00, ALUop=10; then WB.
- ITYPE, LOAD, STORE, JALR: ALUsrcA=10, ALUsrcB=10, ALUop=00.
  - ITYPE and JALR go to WB.
  - LOAD and STORE go to MEM.
- BEQ/BLT: ALUsrcA=10, ALUsrcB=00, ALUop=01, PCsrc=01.
  - PCWrite = zero (BEQ) or lt (BLT).
  - inst_done=1; then IF.
- JAL: RegWrite=1, MemtoReg=10, PCWrite=1, PCsrc=01, inst_done=1; then IF.
- AUIPC: RegWrite=1, MemtoReg=00, inst_done=1; then IF.
REQ-010 MEM SHALL drive IorD=1 with MemRead=1 (LOAD) or MemWrite=1 (STORE) and hold until mem_ready=1.
- LOAD then goes to WB.
- STORE drives inst_done=mem_ready, then goes to IF.
REQ-011 WB SHALL drive RegWrite=1 and inst_done=1, then go to IF:
- RTYPE/ITYPE: MemtoReg=00.
- LOAD: MemtoReg=01.
- JALR: MemtoReg=10, PCWrite=1, PCsrc=10. The ALU inputs SHALL stay as in EX so the target is still on the ALU result.
REQ-012 Instruction latency with mem_ready tied to 1 SHALL be:
- 3 cycles: BEQ, BLT, JAL, AUIPC.
- 4 cycles: RTYPE, ITYPE, STORE, JALR.
- 5 cycles: LOAD.
Each wait cycle on mem_ready SHALL add exactly 1 cycle.
REQ-013 Undefined state encodings 5-7 SHALL go to IF on the next edge with all writes 0.

Reset
REQ-014 With rst=1 at a clock edge, the state SHALL become IF and the latched class SHALL become RTYPE.
REQ-015 While rst=1, PCWrite, IRWrite, RegWrite, MemWrite, inst_done and illegal SHALL be forced to 0, including when rst is asserted mid-MEM.
REQ-016 The first cycle after rst deasserts SHALL be IF.

Structure
REQ-017 A shared package riscv_ctrl_pkg SHALL hold:
- the state encoding;
- the opcode constants;
- the class enum;
- the ALUsrcA/ALUsrcB/ALUop/MemtoReg/PCsrc selector encodings.
REQ-018 Opcode/funct3 classification SHALL be one combinational sub-module, ctrl_class_decode; the FSM SHALL be the only sequential logic.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- rst=1 during MEM of a STORE with mem_ready=0 -> MemWrite=0 that cycle; state=0 on the next edge.
- add (0x002081B3), mem_ready=1 -> states 0,1,2,4,0; RegWrite=1 only in WB; inst_done on cycle 4.
- lw with mem_ready=0 for 2 MEM cycles -> 7 cycles total; MemRead=1 and IorD=1 throughout MEM; MemtoReg=01 in WB.
- beq with zero=1, then blt with lt=0 -> PCWrite=1 in EX for the first; PCWrite=0 for the second; both take 3 cycles.
- jalr -> WB drives PCsrc=10, MemtoReg=10, RegWrite=1, PCWrite=1.
- opcode 0x7F -> illegal pulses in ID; no writes; returns to IF next cycle.
